keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//   Scans the trainer board's 4x4 hex keypad matrix. Drives one column low at a time
//   from a shared divided scan tick and samples the active-low rows. Debounces whole
//   scan frames and reports one key code per press over a valid/ready handshake.
//   Sits between the keypad pins and the front-panel/monitor logic; replaces per-key debouncers.
// PARAMETERS
//   TICK_MAX    24'd29999  scan tick every TICK_MAX+1 clk (400 Hz at 12 MHz); >= 1
//   STABLE_CNT  4          consecutive identical frames required for press and for release; 1..15
// PORTS
//   clk       in   1  system clock
//   rst       in   1  synchronous reset, active-high
//   colN      out  4  column drive, active-low, exactly one bit low
//   rowN      in   4  row sense, active-low (pulled up externally)
//   keyValid  out  1  key event available; held until accepted
//   keyCode   out  4  event code = row*4 + col; stable while keyValid=1
//   keyReady  in   1  consumer accepts event when keyValid & keyReady at posedge clk
//   keyHeld   out  1  1 while a reported key is still held (states PRESSED and RELEASE)
//   overflow  out  1  sticky; a new press became stable while keyValid=1 and was dropped
// BEHAVIOUR
//   Reset (rst=1 at posedge clk) sets: tickCnt=0, col=0, colN=4'b1110, frame snapshot=0,
//     stableCnt=0, state=IDLE, keyValid=0, keyCode=0, keyHeld=0, overflow=0.
//   rst mid-operation: all state returns to these values on that edge; no event is emitted.
//   Tick generator: tickCnt counts 0..TICK_MAX and wraps. tick=1 for one clk when tickCnt==TICK_MAX.
//   Column scan: colN = ~(4'b1 << col). On tick, snap[col*4 +: 4] <= ~rowN, then col <= col+1 (mod 4).
//     The rows are sampled at the end of each column period. A frame is complete on the tick where col==3.
//   Frame classification, on the frame-complete edge:
//     NONE   = all 16 bits 0
//     SINGLE = exactly one bit set; code = row*4+col of that bit
//     MULTI  = two or more bits set; handled as ghosting/invalid
//   FSM, evaluated only on frame-complete edges:
//     IDLE     : SINGLE -> DEBOUNCE, cand=code, stableCnt=1; otherwise stay.
//     DEBOUNCE : SINGLE & code==cand -> stableCnt+1.
//                SINGLE & code!=cand -> cand=code, stableCnt=1.
//                NONE or MULTI -> IDLE, stableCnt=0.
//                When the updated stableCnt==STABLE_CNT -> PRESSED and emit cand.
//                  If STABLE_CNT==1, IDLE goes directly to PRESSED and emits.
//     PRESSED  : NONE -> RELEASE, stableCnt=1; SINGLE or MULTI -> stay (no repeat).
//     RELEASE  : NONE -> stableCnt+1; reaching STABLE_CNT -> IDLE, stableCnt=0.
//                SINGLE or MULTI -> PRESSED.
//   Emit: if keyValid=0 (or is being accepted on the same edge), keyCode<=cand and keyValid<=1,
//     registered on the frame-complete edge.
//     Otherwise keyCode and keyValid are unchanged and overflow<=1.
//   Handshake: keyValid&keyReady -> keyValid<=0 next edge. keyReady with keyValid=0 is ignored.
//   Accept and emit on the same edge -> new code loaded, keyValid stays 1, no overflow.
//   Latency: keyValid rises on the clk edge of the tick ending the STABLE_CNT-th consecutive
//     SINGLE frame, i.e. STABLE_CNT*4*(TICK_MAX+1) clk after the first qualifying frame starts.
//   Width rules: stableCnt is 4 bits and saturates at STABLE_CNT. col is 2 bits and wraps 3->0.
// TESTING (bench TICK_MAX=3, STABLE_CNT=4: tick every 4 clk, frame = 16 clk)
//   1. Reset, then 20 clk with rowN=4'hF -> colN sequence 1110,1101,1011,0111,1110, 4 clk each;
//      keyValid=0, keyHeld=0, overflow=0.
//   2. Key row2/col1 (rowN[2]=0 whenever colN[1]=0) held 6 frames -> keyValid=1 at end of frame 4,
//      keyCode=9, keyHeld=1; keyReady=1 for one clk -> keyValid=0 next clk.
//   3. Key 9 present on alternate frames for 10 frames -> keyValid never asserts; state cycles IDLE/DEBOUNCE.
//   4. Keys 0 and 5 held together 5 frames -> no event; release key 0, key 5 alone for 4 frames
//      -> keyValid=1, keyCode=5.
//   5. Key 3 held 20 frames -> exactly one event. Then 4 empty frames -> keyHeld=0.
//      Press 3 again for 4 frames -> second event with keyCode=3.
//   6. keyReady=0: report key 3, release, press key 7 stable -> overflow=1, keyValid=1, keyCode=3.
//      Also: rst asserted in frame 2 of a debounce -> all outputs reset next clk; 4 fresh frames needed for an event.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad matrix scanner with whole-frame debouncing.
// Reports one key code per stable press over a valid/ready handshake.
module keypad_scan_ctrl #(
    parameter logic [23:0]  TICK_MAX   = 24'd29999,
    parameter int unsigned  STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] colN,
    input  logic [3:0] rowN,
    output logic       keyValid,
    output logic [3:0] keyCode,
    input  logic       keyReady,
    output logic       keyHeld,
    output logic       overflow
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  col_n_q, col_n_d;
    logic [15:0] snap_q, snap_d;
    logic [3:0]  stable_cnt_q, stable_cnt_d;
    logic [3:0]  cand_q, cand_d;
    state_e      state_q, state_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_held_q, key_held_d;
    logic        overflow_q, overflow_d;

    logic        tick_c;
    logic        frame_done_c;
    logic [15:0] frame_c;
    logic [4:0]  hit_cnt_c;
    logic [3:0]  hit_idx_c;
    logic [3:0]  code_c;
    logic        is_none_c;
    logic        is_single_c;
    logic [3:0]  stable_inc_c;
    logic        emit_c;

    assign tick_c       = (tick_cnt_q == TICK_MAX);
    assign frame_done_c = tick_c && (col_q == 2'd3);
    // The last column is still on the pins when the frame completes, so merge it in live.
    assign frame_c      = {~rowN, snap_q[11:0]};

    // Snapshot bit index is col*4+row; count hits and remember the last one.
    always_comb begin
        hit_cnt_c = '0;
        hit_idx_c = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_c[i]) begin
                hit_cnt_c = hit_cnt_c + 5'd1;
                hit_idx_c = 4'(i);
            end
        end
    end

    assign is_none_c    = (hit_cnt_c == 5'd0);
    assign is_single_c  = (hit_cnt_c == 5'd1);
    assign code_c       = {hit_idx_c[1:0], hit_idx_c[3:2]};
    assign stable_inc_c = (stable_cnt_q >= STABLE_MAX) ? STABLE_MAX : stable_cnt_q + 4'd1;

    always_comb begin
        tick_cnt_d   = tick_c ? 24'd0 : tick_cnt_q + 24'd1;
        col_d        = tick_c ? col_q + 2'd1 : col_q;
        col_n_d      = ~(4'b0001 << col_d);
        snap_d       = snap_q;
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        cand_d       = cand_q;
        emit_c       = 1'b0;
        key_valid_d  = key_valid_q;
        key_code_d   = key_code_q;
        overflow_d   = overflow_q;

        if (tick_c) begin
            snap_d[{col_q, 2'b00} +: 4] = ~rowN;
        end

        if (frame_done_c) begin
            case (state_q)
                IDLE: begin
                    if (is_single_c) begin
                        cand_d       = code_c;
                        stable_cnt_d = 4'd1;
                        if (STABLE_MAX == 4'd1) begin
                            state_d = PRESSED;
                            emit_c  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (is_single_c) begin
                        if (code_c == cand_q) begin
                            stable_cnt_d = stable_inc_c;
                        end else begin
                            cand_d       = code_c;
                            stable_cnt_d = 4'd1;
                        end
                        if (stable_cnt_d == STABLE_MAX) begin
                            state_d = PRESSED;
                            emit_c  = 1'b1;
                        end
                    end else begin
                        state_d      = IDLE;
                        stable_cnt_d = 4'd0;
                    end
                end
                PRESSED: begin
                    if (is_none_c) begin
                        state_d      = RELEASE;
                        stable_cnt_d = 4'd1;
                    end
                end
                RELEASE: begin
                    if (is_none_c) begin
                        stable_cnt_d = stable_inc_c;
                        if (stable_inc_c == STABLE_MAX) begin
                            state_d      = IDLE;
                            stable_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Accept first, so an emit on the same edge reloads instead of overflowing.
        if (key_valid_q && keyReady) begin
            key_valid_d = 1'b0;
        end
        if (emit_c) begin
            if (!key_valid_q || keyReady) begin
                key_valid_d = 1'b1;
                key_code_d  = cand_d;
            end else begin
                overflow_d = 1'b1;
            end
        end

        key_held_d = (state_d == PRESSED) || (state_d == RELEASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            col_q        <= '0;
            col_n_q      <= 4'b1110;
            snap_q       <= '0;
            stable_cnt_q <= '0;
            cand_q       <= '0;
            state_q      <= IDLE;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            key_held_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            col_q        <= col_d;
            col_n_q      <= col_n_d;
            snap_q       <= snap_d;
            stable_cnt_q <= stable_cnt_d;
            cand_q       <= cand_d;
            state_q      <= state_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_held_q   <= key_held_d;
            overflow_q   <= overflow_d;
        end
    end

    assign colN     = col_n_q;
    assign keyValid = key_valid_q;
    assign keyCode  = key_code_q;
    assign keyHeld  = key_held_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: frame-level vector table, hand-written corner sequences
// and a randomized phase, all checked every cycle against a run-length reference model.
module tb_keypad_scan_ctrl;

    localparam logic [23:0] TICK_MAX  = 24'd3;
    localparam int          STABLE    = 4;
    localparam int          FRAME_CLK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  colN;
    logic [3:0]  rowN;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic        keyReady = 1'b0;
    logic        keyHeld;
    logic        overflow;
    logic [15:0] mask = '0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.TICK_MAX(TICK_MAX), .STABLE_CNT(STABLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .colN     (colN),
        .rowN     (rowN),
        .keyValid (keyValid),
        .keyCode  (keyCode),
        .keyReady (keyReady),
        .keyHeld  (keyHeld),
        .overflow (overflow)
    );

    // Physical keypad: a pressed key (bit row*4+col) pulls its row low while its column is driven.
    always_comb begin
        rowN = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (colN[c] === 1'b0 && mask[r*4+c]) rowN[r] = 1'b0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame history as run lengths of identical frames.
    int         k;
    bit         m_valid;
    logic [3:0] m_code;
    bit         m_ovf;
    bit         m_held;
    int         none_run;
    int         single_run;
    int         single_code;

    function automatic logic [15:0] key(input int code);
        logic [15:0] one;
        one = 16'd1;
        return one << code;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; m_valid = 0; m_code = '0; m_ovf = 0; m_held = 0;
        none_run = 0; single_run = 0; single_code = 0;
    endtask

    task automatic model_frame(output bit emit, output logic [3:0] code);
        int pc;
        int idx;
        pc = 0; idx = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) begin pc++; idx = i; end
        if (pc == 0) begin
            none_run++; single_run = 0;
        end else if (pc == 1) begin
            if (single_run > 0 && idx == single_code) single_run++;
            else begin single_run = 1; single_code = idx; end
            none_run = 0;
        end else begin
            none_run = 0; single_run = 0;
        end
        emit = 0; code = 4'(idx);
        if (m_held) begin
            if (none_run == STABLE) m_held = 0;
        end else if (single_run == STABLE) begin
            emit = 1; m_held = 1;
        end
    endtask

    task automatic model_edge(input bit r, input bit rdy);
        bit         emit;
        logic [3:0] code;
        if (r) begin
            model_reset();
        end else begin
            k++;
            emit = 0; code = '0;
            if (k % FRAME_CLK == 0) model_frame(emit, code);
            if (emit) begin
                if (!m_valid || rdy) begin m_valid = 1; m_code = code; end
                else m_ovf = 1;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] one;
        logic [3:0] exp_col;
        one = 4'b0001;
        exp_col = ~(one << ((k / 4) % 4));
        chk("colN", 32'(colN), 32'(exp_col));
        chk("keyValid", 32'(keyValid), 32'(m_valid));
        chk("keyCode", 32'(keyCode), 32'(m_code));
        chk("keyHeld", 32'(keyHeld), 32'(m_held));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input bit r, input bit rdy);
        rst = r; keyReady = rdy;
        @(posedge clk);
        model_edge(r, rdy);
        #1;
        check_all();
    endtask

    task automatic run_frames(input int n, input bit pulse);
        for (int f = 0; f < n; f++)
            for (int c = 0; c < FRAME_CLK; c++)
                cyc(1'b0, pulse && f == 0 && c == 0);
    endtask

    typedef struct {
        logic [15:0] mask;
        int          frames;
        bit          pulse;
        bit          exp_valid;
        logic [3:0]  exp_code;
        bit          exp_held;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [15:0] m, input int f, input bit p,
                                input bit v, input logic [3:0] c, input bit h, input bit o);
        vec_t e;
        e.mask = m; e.frames = f; e.pulse = p;
        e.exp_valid = v; e.exp_code = c; e.exp_held = h; e.exp_ovf = o;
        vecs.push_back(e);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish (n_fail=%0d)", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        // Idle scan, then key 9 held 6 frames with a one-clock accept.
        add(16'h0,    2, 0, 0, 4'd0, 0, 0);
        add(key(9),   3, 0, 0, 4'd0, 0, 0);
        add(key(9),   1, 0, 1, 4'd9, 1, 0);
        add(key(9),   2, 1, 0, 4'd9, 1, 0);
        add(16'h0,    4, 0, 0, 4'd9, 0, 0);
        for (int i = 0; i < 5; i++) begin
            add(key(9), 1, 0, 0, 4'd9, 0, 0);
            add(16'h0,  1, 0, 0, 4'd9, 0, 0);
        end
        // Two keys together are ignored, then the survivor debounces on its own.
        add(key(0) | key(5), 5, 0, 0, 4'd9, 0, 0);
        add(key(5),   3, 0, 0, 4'd9, 0, 0);
        add(key(5),   1, 0, 1, 4'd5, 1, 0);
        add(key(5),   1, 1, 0, 4'd5, 1, 0);
        add(16'h0,    4, 0, 0, 4'd5, 0, 0);
        // Long hold gives exactly one event; release and press again.
        add(key(3),   3, 0, 0, 4'd5, 0, 0);
        add(key(3),   1, 0, 1, 4'd3, 1, 0);
        add(key(3),   1, 1, 0, 4'd3, 1, 0);
        add(key(3),  15, 0, 0, 4'd3, 1, 0);
        add(16'h0,    3, 0, 0, 4'd3, 1, 0);
        add(16'h0,    1, 0, 0, 4'd3, 0, 0);
        add(key(3),   4, 0, 1, 4'd3, 1, 0);
        // Unaccepted event followed by another press overflows.
        add(16'h0,    4, 0, 1, 4'd3, 0, 0);
        add(key(7),   4, 0, 1, 4'd3, 1, 1);
        add(16'h0,    4, 0, 1, 4'd3, 0, 1);

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        cyc(1'b1, 1'b0);
        chk("reset colN", 32'(colN), 32'h0000_000E);

        foreach (vecs[i]) begin
            mask = vecs[i].mask;
            run_frames(vecs[i].frames, vecs[i].pulse);
            chk($sformatf("vec%0d keyValid", i), 32'(keyValid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d keyCode", i),  32'(keyCode),  32'(vecs[i].exp_code));
            chk($sformatf("vec%0d keyHeld", i),  32'(keyHeld),  32'(vecs[i].exp_held));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // Reset in the second frame of a debounce discards it.
        mask = key(2);
        run_frames(1, 0);
        repeat (8) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rst keyValid", 32'(keyValid), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst keyHeld",  32'(keyHeld),  32'd0);
        chk("rst keyCode",  32'(keyCode),  32'd0);
        chk("rst colN",     32'(colN),     32'h0000_000E);
        run_frames(3, 0);
        chk("post-rst 3 frames keyValid", 32'(keyValid), 32'd0);
        run_frames(1, 0);
        chk("post-rst 4 frames keyValid", 32'(keyValid), 32'd1);
        chk("post-rst 4 frames keyCode",  32'(keyCode),  32'd2);

        // Accept coinciding with a new emit reloads the code without overflow.
        mask = '0;
        run_frames(4, 0);
        mask = key(6);
        run_frames(3, 0);
        repeat (FRAME_CLK - 1) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("accept+emit keyValid", 32'(keyValid), 32'd1);
        chk("accept+emit keyCode",  32'(keyCode),  32'd6);
        chk("accept+emit overflow", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b1);
        chk("accept keyValid", 32'(keyValid), 32'd0);
        mask = '0;
        run_frames(4, 0);

        // Randomized frame patterns and consumer readiness.
        for (int s = 0; s < 150; s++) begin
            int sel;
            int nf;
            int a;
            sel = int'($urandom_range(0, 9));
            nf  = int'($urandom_range(1, 6));
            if (sel <= 3) begin
                mask = '0;
            end else if (sel <= 8) begin
                mask = key(int'($urandom_range(0, 15)));
            end else begin
                a = int'($urandom_range(0, 15));
                mask = key(a) | key((a + 1 + int'($urandom_range(0, 14))) % 16);
            end
            if ($urandom_range(0, 19) == 0) cyc(1'b1, 1'b0);
            for (int f = 0; f < nf; f++)
                for (int c = 0; c < FRAME_CLK; c++)
                    cyc(1'b0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
